// File: rtl/pair_printer_pkg.sv
// -----------------------------------------------------------------------------
// printer_pkg
// Shared types and constants for the pair_printer UART serializer.
//
// Contents:
//   ASCII_CR / ASCII_LF  line-terminator characters appended after a line
//   CRLF_ON              1 when PAIR_PRINTER_CRLF_EN is defined, else 0
//   ENTRY_W              FIFO entry width (17 with CRLF, 16 without)
//   txState_e            UART transmit FSM states
//   byteSel_e            which byte of the current entry is on the wire
//   pair_entry_t         unpacked view of one buffered pair
//
// Configuration macro: PAIR_PRINTER_CRLF_EN
// -----------------------------------------------------------------------------
package printer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef PAIR_PRINTER_CRLF_EN
    localparam bit CRLF_ON = 1'b1;
    localparam int ENTRY_W = 17;
`else
    localparam bit CRLF_ON = 1'b0;
    localparam int ENTRY_W = 16;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_e;

    typedef enum logic [1:0] {
        SEL_LHS,
        SEL_RHS,
        SEL_CR,
        SEL_LF
    } byteSel_e;

    typedef struct packed {
        logic [7:0] lhs;
        logic [7:0] rhs;
        logic       last;
    } pair_entry_t;

endpackage

// File: rtl/pair_printer_fifo.sv
// -----------------------------------------------------------------------------
// pair_fifo
// Synchronous FIFO with asynchronous active-low reset. Pointers carry one
// extra wrap bit so that full and empty are told apart by the occupancy
// count (write pointer minus read pointer, modulo 2*DEPTH).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low; flushes the FIFO
//   push_i     write wrData_i (ignored while full)
//   wrData_i   entry to write
//   pop_i      drop the head entry (ignored while empty)
//   rdData_o   head entry (valid while not empty)
//   full_o     count == DEPTH
//   empty_o    count == 0
//   count_o    current occupancy
// -----------------------------------------------------------------------------
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wrData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign count_o  = wrPtr_q - rdPtr_q;
    assign full_o   = (count_o == DEPTH_CNT);
    assign empty_o  = (count_o == '0);
    assign doPush   = push_i && !full_o;
    assign doPop    = pop_i && !empty_o;
    assign rdData_o = mem_q[rdPtr_q[AW-1:0]];

    // Pointer registers; wrap is natural modulo of the AW+1 bit counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // Storage is not reset: a flush only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
        end
    end

endmodule

// File: rtl/pair_printer.sv
// -----------------------------------------------------------------------------
// pair_printer
// Buffers (lhs, rhs) ASCII character pairs in a small FIFO and serializes
// them on a UART 8N1 line: lhs byte, then rhs byte, optionally followed by
// CR LF after a pair that ends a line. Frames run back to back while data
// remains; the line idles high otherwise.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..255)
//   FIFO_DEPTH    buffered pairs (power of two, >= 2)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   in_valid  a pair is presented on lhs/rhs/in_last
//   in_ready  FIFO can accept a pair (low during reset)
//   lhs       input-side ASCII character
//   rhs       transformed ASCII character
//   in_last   pair ends a line (used only with CRLF enabled)
//   tx        UART serial output, idles high
//   busy      FIFO non-empty or a frame in flight
//
// Configuration macro: PAIR_PRINTER_CRLF_EN (append CR LF after last pairs)
// -----------------------------------------------------------------------------
module pair_printer
    import printer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    input  logic       in_last,
    output logic       tx,
    output logic       busy
);

    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  BAUD_RELOAD = 8'(CLKS_PER_BIT - 1);

    txState_e            state_q,     state_d;
    byteSel_e            byteSel_q,   byteSel_d;
    pair_entry_t         curEntry_q,  curEntry_d;
    logic [7:0]          shiftReg_q,  shiftReg_d;
    logic [7:0]          baudCnt_q,   baudCnt_d;
    logic [2:0]          bitCnt_q,    bitCnt_d;
    logic                tx_q,        tx_d;
    logic                readyEn_q;

    logic                fifoPush;
    logic                fifoPop;
    logic [ENTRY_W-1:0]  fifoWrData;
    logic [ENTRY_W-1:0]  fifoRdData;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [CNT_W-1:0]    fifoCount;
    pair_entry_t         headEntry;

    logic                bitDone;
    logic                hasNext;
    logic [7:0]          nextByte;
    byteSel_e            nextSel;

    // readyEn_q holds in_ready low through reset and rises on the first edge
    // after release; otherwise in_ready follows the registered count only.
    assign in_ready = readyEn_q && !fifoFull;
    assign fifoPush = in_valid && in_ready;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || (fifoCount != '0);
    assign bitDone  = (baudCnt_q == 8'd0);

`ifdef PAIR_PRINTER_CRLF_EN
    assign fifoWrData = {lhs, rhs, in_last};
    always_comb begin
        headEntry.lhs  = fifoRdData[16:9];
        headEntry.rhs  = fifoRdData[8:1];
        headEntry.last = fifoRdData[0];
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign fifoWrData = {lhs, rhs};
    always_comb begin
        headEntry.lhs  = fifoRdData[15:8];
        headEntry.rhs  = fifoRdData[7:0];
        headEntry.last = 1'b0;
    end
`endif

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (fifoPush),
        .wrData_i (fifoWrData),
        .pop_i    (fifoPop),
        .rdData_o (fifoRdData),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty),
        .count_o  (fifoCount)
    );

    // Byte sequencing within one entry: LHS -> RHS -> (CR -> LF when the
    // entry closes a line and CRLF is built in).
    always_comb begin
        hasNext  = 1'b0;
        nextByte = curEntry_q.rhs;
        nextSel  = SEL_RHS;
        unique case (byteSel_q)
            SEL_LHS: begin
                hasNext  = 1'b1;
                nextByte = curEntry_q.rhs;
                nextSel  = SEL_RHS;
            end
            SEL_RHS: begin
                if (CRLF_ON && curEntry_q.last) begin
                    hasNext  = 1'b1;
                    nextByte = ASCII_CR;
                    nextSel  = SEL_CR;
                end
            end
            SEL_CR: begin
                hasNext  = 1'b1;
                nextByte = ASCII_LF;
                nextSel  = SEL_LF;
            end
            SEL_LF: begin
                hasNext = 1'b0;
            end
        endcase
    end

    // Transmit FSM. tx is registered, so every transition that starts a new
    // bit also sets the level that bit will drive from the next cycle on.
    always_comb begin
        state_d    = state_q;
        byteSel_d  = byteSel_q;
        curEntry_d = curEntry_q;
        shiftReg_d = shiftReg_q;
        baudCnt_d  = baudCnt_q;
        bitCnt_d   = bitCnt_q;
        tx_d       = tx_q;
        fifoPop    = 1'b0;

        if (state_q != IDLE && !bitDone) begin
            baudCnt_d = baudCnt_q - 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    curEntry_d = headEntry;
                    shiftReg_d = headEntry.lhs;
                    byteSel_d  = SEL_LHS;
                    tx_d       = 1'b0;
                    baudCnt_d  = BAUD_RELOAD;
                    state_d    = START;
                end
            end
            START: begin
                if (bitDone) begin
                    tx_d      = shiftReg_q[0];
                    baudCnt_d = BAUD_RELOAD;
                    bitCnt_d  = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    baudCnt_d = BAUD_RELOAD;
                    if (bitCnt_q == 3'd7) begin
                        tx_d     = 1'b1;
                        bitCnt_d = 3'd0;
                        state_d  = STOP;
                    end else begin
                        shiftReg_d = shiftReg_q >> 1;
                        tx_d       = shiftReg_q[1];
                        bitCnt_d   = bitCnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    if (hasNext) begin
                        shiftReg_d = nextByte;
                        byteSel_d  = nextSel;
                        tx_d       = 1'b0;
                        baudCnt_d  = BAUD_RELOAD;
                        state_d    = START;
                    end else if (!fifoEmpty) begin
                        fifoPop    = 1'b1;
                        curEntry_d = headEntry;
                        shiftReg_d = headEntry.lhs;
                        byteSel_d  = SEL_LHS;
                        tx_d       = 1'b0;
                        baudCnt_d  = BAUD_RELOAD;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // State and datapath registers. Reset drives tx high at once and drops
    // any partial byte; the FIFO flushes through its own reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byteSel_q  <= SEL_LHS;
            curEntry_q <= '0;
            shiftReg_q <= '0;
            baudCnt_q  <= '0;
            bitCnt_q   <= '0;
            tx_q       <= 1'b1;
            readyEn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byteSel_q  <= byteSel_d;
            curEntry_q <= curEntry_d;
            shiftReg_q <= shiftReg_d;
            baudCnt_q  <= baudCnt_d;
            bitCnt_q   <= bitCnt_d;
            tx_q       <= tx_d;
            readyEn_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pair_printer.sv
// -----------------------------------------------------------------------------
// tb_pair_printer
// Self-checking bench for pair_printer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A behavioural UART receiver decodes tx into a byte queue with frame start
// times; an expected-byte queue is built from every accepted push using the
// pair/CRLF rules. Works with or without PAIR_PRINTER_CRLF_EN.
// -----------------------------------------------------------------------------
module tb_pair_printer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       in_last;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ [$];
    logic [7:0] rxQ  [$];
    int         rxT  [$];

    int         cyc = 0;
    bit         rxActive = 0;
    int         rxOff = 0;
    int         rxStartCyc = 0;
    logic [7:0] rxByte = '0;
    int         frameErrs = 0;

    pair_printer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lhs      (lhs),
        .rhs      (rhs),
        .in_last  (in_last),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural UART receiver sampling on the falling edge: offset 0 is the
    // first start-bit cycle, each bit is sampled in its middle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            rxActive = 0;
        end else if (!rxActive) begin
            if (tx === 1'b0) begin
                rxActive   = 1;
                rxOff      = 0;
                rxStartCyc = cyc;
            end
        end else begin
            rxOff = rxOff + 1;
            if (rxOff == CPB / 2 && tx !== 1'b0) frameErrs = frameErrs + 1;
            for (int j = 0; j < 8; j++) begin
                if (rxOff == (j + 1) * CPB + CPB / 2) rxByte[j] = tx;
            end
            if (rxOff == 9 * CPB + CPB / 2 && tx !== 1'b1) frameErrs = frameErrs + 1;
            if (rxOff == 10 * CPB - 1) begin
                rxQ.push_back(rxByte);
                rxT.push_back(rxStartCyc);
                rxActive = 0;
            end
        end
    end

    // Presents one pair and holds it until accepted; records the model bytes.
    task automatic applyStimulus(input logic [7:0] l, input logic [7:0] r,
                                 input logic last, output int stalls);
        bit acc;
        stalls   = 0;
        in_valid = 1'b1;
        lhs      = l;
        rhs      = r;
        in_last  = last;
        forever begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
            if (stalls > 2000) begin
                checks++;
                errors++;
                $display("[TB] FAIL push_timeout: got no in_ready, expected accept within 2000 cycles");
                break;
            end
        end
        if (acc) begin
            expQ.push_back(l);
            expQ.push_back(r);
`ifdef PAIR_PRINTER_CRLF_EN
            if (last) begin
                expQ.push_back(8'h0D);
                expQ.push_back(8'h0A);
            end
`endif
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!busy && !rxActive) break;
            n++;
            if (n > 5000) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout: busy=%0b rxActive=%0b, expected idle within 5000 cycles", busy, rxActive);
                break;
            end
        end
    endtask

    task automatic clearQueues();
        expQ.delete();
        rxQ.delete();
        rxT.delete();
        frameErrs = 0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        lhs      = '0;
        rhs      = '0;
        in_last  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_in_ready_before_edge: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_pair();
        int st;
        int busyCycles;
        clearQueues();
        applyStimulus(8'h61, 8'h7A, 1'b0, st);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_push_cycle: got %b expected 1", tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("[TB] FAIL single_tx_fall_latency: got %b expected 0", tx); end
        busyCycles = (busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busyCycles++;
        end
        checks++;
        if (busyCycles != 20 * CPB) begin
            errors++;
            $display("[TB] FAIL single_busy_length: got %0d cycles expected %0d", busyCycles, 20 * CPB);
        end
        waitDrain();
        checks++;
        if (rxQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL single_byte_count: got %0d expected %0d", rxQ.size(), expQ.size());
        end else begin
            for (int k = 0; k < rxQ.size(); k++) begin
                checks++;
                if (rxQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL single_byte[%0d]: got %h expected %h", k, rxQ[k], expQ[k]); end
            end
            for (int k = 1; k < rxT.size(); k++) begin
                checks++;
                if (rxT[k] - rxT[k-1] != 10 * CPB) begin errors++; $display("[TB] FAIL single_gap[%0d]: got %0d expected %0d", k, rxT[k] - rxT[k-1], 10 * CPB); end
            end
        end
        checks++;
        if (frameErrs != 0) begin errors++; $display("[TB] FAIL single_framing: got %0d errors expected 0", frameErrs); end
    endtask

    task automatic test_backpressure();
        int st;
        int acceptedBeforeStall = -1;
        bit sawStall = 0;
        clearQueues();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), st);
            if (st > 0 && !sawStall) begin
                sawStall = 1;
                acceptedBeforeStall = i;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acceptedBeforeStall != DEPTH + 1) begin
            errors++;
            $display("[TB] FAIL bp_first_stall: got %0d accepted expected %0d", acceptedBeforeStall, DEPTH + 1);
        end
        waitDrain();
        checks++;
        if (rxQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL bp_byte_count: got %0d expected %0d", rxQ.size(), expQ.size());
        end else begin
            for (int k = 0; k < rxQ.size(); k++) begin
                checks++;
                if (rxQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL bp_byte[%0d]: got %h expected %h", k, rxQ[k], expQ[k]); end
            end
            for (int k = 1; k < rxT.size(); k++) begin
                checks++;
                if (rxT[k] - rxT[k-1] != 10 * CPB) begin errors++; $display("[TB] FAIL bp_gap[%0d]: got %0d expected %0d", k, rxT[k] - rxT[k-1], 10 * CPB); end
            end
        end
        checks++;
        if (frameErrs != 0) begin errors++; $display("[TB] FAIL bp_framing: got %0d errors expected 0", frameErrs); end
    endtask

    task automatic test_crlf();
        int st;
        clearQueues();
        applyStimulus(8'h41, 8'h42, 1'b1, st);
        in_valid = 1'b0;
        waitDrain();
        checks++;
        if (rxQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL crlf_byte_count: got %0d expected %0d", rxQ.size(), expQ.size());
        end else begin
            for (int k = 0; k < rxQ.size(); k++) begin
                checks++;
                if (rxQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL crlf_byte[%0d]: got %h expected %h", k, rxQ[k], expQ[k]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int st;
        int stallSum = 0;
        bit txLowSeen = 0;
        logic [7:0] firstByte;
        clearQueues();
        // Second byte on the wire is rhs of pair 0; bit 0 is forced low so
        // that the reset visibly pulls tx from 0 to 1.
        applyStimulus(8'($urandom), 8'($urandom) & 8'hFE, 1'($urandom), st);
        stallSum += st;
        applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), st);
        stallSum += st;
        applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), st);
        stallSum += st;
        in_valid = 1'b0;
        firstByte = expQ[0];
        // First push on edge N: second byte starts on N+41, data bit 0 spans
        // N+45..N+48. Now just after N+2; go to the falling edge after N+46.
        repeat (44) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stallSum != 0) begin errors++; $display("[TB] FAIL rmf_setup_stalls: got %0d expected 0", stallSum); end
        checks++;
        if (tx !== 1'b0) begin errors++; $display("[TB] FAIL rmf_data_bit_before_reset: got %b expected 0", tx); end
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rmf_tx_async: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_busy_in_reset: got %b expected 0", busy); end
        checks++;
        if (rxQ.size() != 1) begin
            errors++;
            $display("[TB] FAIL rmf_bytes_before_reset: got %0d expected 1", rxQ.size());
        end else begin
            checks++;
            if (rxQ[0] !== firstByte) begin errors++; $display("[TB] FAIL rmf_first_byte: got %h expected %h", rxQ[0], firstByte); end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_busy_after_release: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmf_in_ready_after_release: got %b expected 1", in_ready); end
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) txLowSeen = 1;
        end
        checks++;
        if (txLowSeen) begin errors++; $display("[TB] FAIL rmf_no_restart: got a start bit expected tx idle"); end
        checks++;
        if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL rmf_no_new_bytes: got %0d bytes expected 1", rxQ.size()); end
    endtask

    task automatic test_pointer_wrap();
        int st;
        clearQueues();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), st);
        end
        in_valid = 1'b0;
        waitDrain();
        checks++;
        if (rxQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL wrap_byte_count: got %0d expected %0d", rxQ.size(), expQ.size());
        end else begin
            for (int k = 0; k < rxQ.size(); k++) begin
                checks++;
                if (rxQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL wrap_byte[%0d]: got %h expected %h", k, rxQ[k], expQ[k]); end
            end
            for (int k = 1; k < rxT.size(); k++) begin
                checks++;
                if (rxT[k] - rxT[k-1] != 10 * CPB) begin errors++; $display("[TB] FAIL wrap_gap[%0d]: got %0d expected %0d", k, rxT[k] - rxT[k-1], 10 * CPB); end
            end
        end
        checks++;
        if (frameErrs != 0) begin errors++; $display("[TB] FAIL wrap_framing: got %0d errors expected 0", frameErrs); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_pair();
        test_backpressure();
        test_crlf();
        test_reset_mid_frame();
        test_pointer_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
